sample_jitter: RTL

SAMPLE_JITTER -- requirements
Module: sample_jitter

---
 rtl/sample_jitter_pkg.sv | 35 +++
 rtl/jitter_offset.sv | 33 +++
 rtl/sample_jitter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sample_jitter_pkg.sv
// Shared rasterizer definitions for the sample jitter block.
//   SIGFIG / RADIX  : default coordinate width and fractional bit count
//   SS_*            : one-hot subSample encodings (samples per pixel)
//   ss_decode()     : maps a subSample code to its shift index k and legality
package sample_jitter_pkg;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;

    localparam logic [3:0] SS_1  = 4'b1000;
    localparam logic [3:0] SS_4  = 4'b0100;
    localparam logic [3:0] SS_16 = 4'b0010;
    localparam logic [3:0] SS_64 = 4'b0001;

    typedef struct packed {
        logic       legal;
        logic [1:0] k;
    } ss_decode_t;

    // Finer sample grids use smaller jitter steps: k grows with sample count.
    function automatic ss_decode_t ss_decode(input logic [3:0] code);
        ss_decode_t r;
        r.legal = 1'b1;
        r.k     = 2'd0;
        case (code)
            SS_1:    r.k = 2'd0;
            SS_4:    r.k = 2'd1;
            SS_16:   r.k = 2'd2;
            SS_64:   r.k = 2'd3;
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jitter_offset.sv
// Combinational jitter offset for one coordinate.
//   nibble : 4-bit hash slice for this axis
//   k      : subSample shift index (0..3)
//   apply  : jitter enabled and subSample code legal
//   offset : nibble << (RADIX-4-k), zero-extended; zero when apply is low
module jitter_offset #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10
) (
    input  logic [3:0]        nibble,
    input  logic [1:0]        k,
    input  logic              apply,
    output logic [SIGFIG-1:0] offset
);

    logic [SIGFIG-1:0] nib_ext;
    logic [SIGFIG-1:0] shifted [4];

    assign nib_ext = {{(SIGFIG-4){1'b0}}, nibble};

    // One constant shift per k; the mux below picks the one in use.
    for (genvar gi = 0; gi < 4; gi++) begin : g_shift
        assign shifted[gi] = nib_ext << (RADIX - 4 - gi);
    end

    always_comb begin
        offset = '0;
        if (apply) begin
            offset = shifted[k];
        end
    end

endmodule

// File: rtl/sample_jitter.sv
// Two-stage sample jitter pipeline with valid/ready handshakes.
//   clk, rst                        : clock, synchronous active-high reset
//   in_valid/in_ready               : input handshake
//   sample_x/y, hash, subSample,
//   jitter_en                       : per-sample input fields
//   out_valid/out_ready             : output handshake
//   jit_x/jit_y                     : jittered coordinates (driven from S2)
//   count_RnnU                      : delivered sample count, wraps at 16 bits
//   err_RnnH                        : sticky illegal-subSample flag
module sample_jitter #(
    parameter int SIGFIG     = sample_jitter_pkg::SIGFIG,
    parameter int RADIX      = sample_jitter_pkg::RADIX,
    parameter int HASH_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_RnnH,
    output logic                  in_ready_RnnH,
    input  logic [SIGFIG-1:0]     sample_x_RnnS,
    input  logic [SIGFIG-1:0]     sample_y_RnnS,
    input  logic [HASH_WIDTH-1:0] hash_RnnH,
    input  logic [3:0]            subSample_RnnH,
    input  logic                  jitter_en_RnnH,
    output logic                  out_valid_RnnH,
    input  logic                  out_ready_RnnH,
    output logic [SIGFIG-1:0]     jit_x_RnnS,
    output logic [SIGFIG-1:0]     jit_y_RnnS,
    output logic [15:0]           count_RnnU,
    output logic                  err_RnnH
);
    import sample_jitter_pkg::*;

    // S1: raw sample plus its decoded jitter controls.
    logic              s1_valid_q, s1_valid_d;
    logic [SIGFIG-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic [3:0]        s1_nx_q, s1_nx_d, s1_ny_q, s1_ny_d;
    logic [1:0]        s1_k_q, s1_k_d;
    logic              s1_apply_q, s1_apply_d;
    // S2: jittered result.
    logic              s2_valid_q, s2_valid_d;
    logic [SIGFIG-1:0] s2_x_q, s2_x_d, s2_y_q, s2_y_d;
    logic [15:0]       count_q, count_d;
    logic              err_q, err_d;

    logic              s1_load, s2_load, in_fire;
    logic [SIGFIG-1:0] off_x, off_y;
    ss_decode_t        in_dec;

    assign in_dec  = ss_decode(subSample_RnnH);
    assign s2_load = !s2_valid_q || out_ready_RnnH;
    assign s1_load = !s1_valid_q || s2_load;
    assign in_fire = in_valid_RnnH && s1_load;

    jitter_offset #(.SIGFIG(SIGFIG), .RADIX(RADIX)) u_off_x (
        .nibble (s1_nx_q),
        .k      (s1_k_q),
        .apply  (s1_apply_q),
        .offset (off_x)
    );

    jitter_offset #(.SIGFIG(SIGFIG), .RADIX(RADIX)) u_off_y (
        .nibble (s1_ny_q),
        .k      (s1_k_q),
        .apply  (s1_apply_q),
        .offset (off_y)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_nx_d    = s1_nx_q;
        s1_ny_d    = s1_ny_q;
        s1_k_d     = s1_k_q;
        s1_apply_d = s1_apply_q;
        s2_valid_d = s2_valid_q;
        s2_x_d     = s2_x_q;
        s2_y_d     = s2_y_q;
        count_d    = count_q;
        err_d      = err_q;

        if (s1_load) begin
            s1_valid_d = in_valid_RnnH;
            if (in_valid_RnnH) begin
                s1_x_d     = sample_x_RnnS;
                s1_y_d     = sample_y_RnnS;
                s1_nx_d    = hash_RnnH[3:0];
                s1_ny_d    = hash_RnnH[7:4];
                s1_k_d     = in_dec.k;
                s1_apply_d = jitter_en_RnnH && in_dec.legal;
            end
        end

        // Data only changes when a real sample moves in, so outputs stay
        // put across bubbles as well as stalls.
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_x_d = s1_x_q + off_x;
                s2_y_d = s1_y_q + off_y;
            end
        end

        if (out_valid_RnnH && out_ready_RnnH) begin
            count_d = count_q + 16'd1;
        end

        if (in_fire && !in_dec.legal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_nx_q    <= '0;
            s1_ny_q    <= '0;
            s1_k_q     <= '0;
            s1_apply_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_x_q     <= '0;
            s2_y_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_nx_q    <= s1_nx_d;
            s1_ny_q    <= s1_ny_d;
            s1_k_q     <= s1_k_d;
            s1_apply_q <= s1_apply_d;
            s2_valid_q <= s2_valid_d;
            s2_x_q     <= s2_x_d;
            s2_y_q     <= s2_y_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    assign in_ready_RnnH  = s1_load;
    assign out_valid_RnnH = s2_valid_q;
    assign jit_x_RnnS     = s2_x_q;
    assign jit_y_RnnS     = s2_y_q;
    assign count_RnnU     = count_q;
    assign err_RnnH       = err_q;

endmodule
